// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit owning the HI/LO register pair.
// Shift-add multiply and restoring divide, one bit per cycle, followed by a
// single sign-fix cycle. Optional divider datapath: define MULDIV_DIVIDER_EN.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // mul: multiplicand magnitude; div: divisor magnitude
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               is_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_fix;
`ifdef MULDIV_DIVIDER_EN
    logic               is_div_q, is_div_d;
    logic               rneg_q, rneg_d;
    logic [WIDTH-1:0]   araw_q, araw_d;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
`endif

    // Operand magnitudes and per-iteration datapath
    always_comb begin
        is_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
        abs_a     = (is_signed && a_i[WIDTH-1]) ? -a_i : a_i;
        abs_b     = (is_signed && b_i[WIDTH-1]) ? -b_i : b_i;
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & opb_q};
        prod_fix  = neg_q ? -acc_q : acc_q;
`ifdef MULDIV_DIVIDER_EN
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opb_q};
        quo_fix   = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
        rem_fix   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif
    end

    // Next-state, operand capture, iteration and HI/LO write-back
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef MULDIV_DIVIDER_EN
        is_div_d = is_div_q;
        rneg_d   = rneg_q;
        araw_d   = araw_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start_i) begin
                    case (op_i)
                        OP_MULT, OP_MULTU: begin
                            state_d = S_CALC;
                            cnt_d   = '0;
                            acc_d   = {{WIDTH{1'b0}}, abs_b};
                            opb_d   = abs_a;
                            neg_d   = is_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
`ifdef MULDIV_DIVIDER_EN
                            is_div_d = 1'b0;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIVIDER_EN
                            state_d  = S_CALC;
                            cnt_d    = '0;
                            acc_d    = {{WIDTH{1'b0}}, abs_a};
                            opb_d    = abs_b;
                            neg_d    = is_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                            rneg_d   = is_signed && a_i[WIDTH-1];
                            araw_d   = a_i;
                            is_div_d = 1'b1;
`else
                            // No divider: acknowledge immediately, HI/LO untouched
                            state_d = S_DONE;
`endif
                        end
                        OP_MTHI: hi_d = a_i;
                        OP_MTLO: lo_d = a_i;
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
`ifdef MULDIV_DIVIDER_EN
                    if (is_div_q) begin
                        // Restoring step: subtract only when no borrow
                        if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        else                  acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end else
`endif
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
            end
            S_FIX: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
`ifdef MULDIV_DIVIDER_EN
                    if (is_div_q) begin
                        // Zero divisor reports the raw dividend, not the sign-fixed one
                        if (opb_q == '0) begin
                            lo_d = '1;
                            hi_d = araw_q;
                        end else begin
                            lo_d = quo_fix;
                            hi_d = rem_fix;
                        end
                    end else
`endif
                    begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MULDIV_DIVIDER_EN
            is_div_q <= 1'b0;
            rneg_q   <= 1'b0;
            araw_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef MULDIV_DIVIDER_EN
            is_div_q <= is_div_d;
            rneg_q   <= rneg_d;
            araw_q   <= araw_d;
`endif
        end
    end

    assign busy_o = (state_q == S_CALC) || (state_q == S_FIX);
    assign done_o = (state_q == S_DONE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors; expected HI/LO and done cycle are queued
// at issue time and checked by a monitor whenever done_o is seen.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3;
    localparam logic [2:0] MTHI = 3'd4, MTLO = 3'd5, ILL = 3'd6;

    logic         clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, flush_i = 1'b0;
    logic [2:0]   op_i = '0;
    logic [W-1:0] a_i = '0, b_i = '0;
    logic         busy_o, done_o;
    logic [W-1:0] hi_o, lo_o;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           n_cmp = 0, n_fail = 0, cyc = 0;
    logic [W-1:0] sh_hi = '0, sh_lo = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .busy_o(busy_o),
        .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done_o pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {63'b0, done_o}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("hi", {32'b0, hi_o}, {32'b0, mon_e.hi});
                chk("lo", {32'b0, lo_o}, {32'b0, mon_e.lo});
            end
        end
    end

    // Queue the response for an op accepted at the coming edge
    task automatic expect_res(input logic [W-1:0] h, input logic [W-1:0] l, input int lat);
        exp_t e;
        e.hi = h; e.lo = l; e.cyc = cyc + 1 + lat;
        sb.push_back(e);
        sh_hi = h; sh_lo = l;
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        op_i = op; a_i = a; b_i = b; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] h, input logic [W-1:0] l);
        expect_res(h, l, W + 1);
        issue(op, a, b);
        wait_drain();
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", {32'b0, hi_o}, 64'd0);
        chk("rst_lo", {32'b0, lo_o}, 64'd0);
        chk("rst_busy", {63'b0, busy_o}, 64'd0);
        chk("rst_done", {63'b0, done_o}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // MULTU max x max, with busy length
        expect_res(32'hFFFF_FFFE, 32'h0000_0001, W + 1);
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n = 0;
        while (busy_o && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("busy_cycles", 64'(n), 64'(W + 1));
        wait_drain();

        run_op(MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op(MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op(MULTU, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780);
        run_op(MULT,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2);

`ifdef MULDIV_DIVIDER_EN
        run_op(DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(DIVU, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF);
        run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op(DIVU, 32'd100,       32'd7,         32'd2,         32'd14);
        run_op(DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
        run_op(DIV,  32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF);
`else
        // No divider: done next cycle, HI/LO unchanged, never busy
        expect_res(sh_hi, sh_lo, 0);
        issue(DIV, 32'd9, 32'd3);
        chk("nodiv_busy0", {63'b0, busy_o}, 64'd0);
        @(posedge clk); #1;
        chk("nodiv_busy1", {63'b0, busy_o}, 64'd0);
        wait_drain();
        chk("nodiv_hi", {32'b0, hi_o}, {32'b0, sh_hi});
`endif

        // MTHI/MTLO write immediately with no handshake
        issue(MTHI, 32'h1234, 32'd0);
        chk("mthi_hi", {32'b0, hi_o}, 64'h1234);
        chk("mthi_busy", {63'b0, busy_o}, 64'd0);
        issue(MTLO, 32'h5678, 32'd0);
        chk("mtlo_lo", {32'b0, lo_o}, 64'h5678);

        // Flush at CALC cycle 10 together with a dropped start
        issue(MULT, 32'd3, 32'd4);
        repeat (9) begin @(posedge clk); #1; end
        flush_i = 1'b1; start_i = 1'b1; op_i = MULTU;
        @(posedge clk); #1;
        flush_i = 1'b0; start_i = 1'b0;
        chk("flush_busy", {63'b0, busy_o}, 64'd0);
        chk("flush_hi", {32'b0, hi_o}, 64'h1234);
        chk("flush_lo", {32'b0, lo_o}, 64'h5678);
        repeat (40) begin @(posedge clk); #1; end

        // Start while busy is ignored: exactly one done
        expect_res(32'd0, 32'd42, W + 1);
        issue(MULTU, 32'd6, 32'd7);
        repeat (5) begin @(posedge clk); #1; end
        issue(MULT, 32'd100, 32'd100);
        wait_drain();
        repeat (40) begin @(posedge clk); #1; end

        // Back-to-back issue in the DONE cycle
        expect_res(32'd0, 32'd6, W + 1);
        issue(MULTU, 32'd2, 32'd3);
        n = 0;
        while (!done_o && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("b2b_done_seen", {63'b0, done_o}, 64'd1);
        expect_res(32'd0, 32'd35, W + 1);
        issue(MULTU, 32'd5, 32'd7);
        wait_drain();

        // Reset in the middle of CALC
        issue(MULTU, 32'd9, 32'd9);
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("arst_hi", {32'b0, hi_o}, 64'd0);
        chk("arst_lo", {32'b0, lo_o}, 64'd0);
        chk("arst_busy", {63'b0, busy_o}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; end
        chk("arst_no_done", {63'b0, done_o}, 64'd0);

        // Reserved op has no effect
        issue(MTHI, 32'hCAFE, 32'd0);
        issue(ILL, 32'hAAAA, 32'hBBBB);
        chk("ill_busy", {63'b0, busy_o}, 64'd0);
        chk("ill_done", {63'b0, done_o}, 64'd0);
        chk("ill_hi", {32'b0, hi_o}, 64'hCAFE);
        chk("ill_lo", {32'b0, lo_o}, 64'd0);

        repeat (5) begin @(posedge clk); #1; end
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit that owns the architectural HI/LO register pair for the MIPS datapath.
- Generalises the C_MULT / C_MUL_U ALU selects to signed and unsigned multiply, optional signed and unsigned divide, and MTHI/MTLO writes, at any even WIDTH.
- Sits beside the single-cycle ALU; the controller issues ops over a start/busy/done handshake and reads hi_o/lo_o for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO. Even, ≥4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  issue request; honoured only when busy_o=0.
- op_i  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6..7 ignored (no effect).
- a_i  in  WIDTH  operand A: multiplicand, dividend, or MTHI/MTLO data.
- b_i  in  WIDTH  operand B: multiplier or divisor.
- flush_i  in  1  abort the in-flight op.
- busy_o  out  1  high while an op is iterating.
- done_o  out  1  one-cycle pulse when HI/LO receive a mul/div result.
- hi_o  out  WIDTH  architectural HI register.
- lo_o  out  WIDTH  architectural LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; hi_o=0, lo_o=0, busy_o=0, done_o=0; any in-flight op is discarded.
- FSM states: IDLE, CALC, FIX, DONE. busy_o=1 in CALC and FIX only.
- Accept: start_i=1 in IDLE or DONE with a legal op, sampled at edge T.
  - MUL/DIV ops capture a_i, b_i, and sign flags; signed ops capture absolute values; then go to CALC.
  - MTHI/MTLO write a_i into hi_o/lo_o at edge T, stay in IDLE, no busy, no done.
  - start_i while busy_o=1 is ignored.
- CALC: WIDTH iterations, one bit per cycle.
  - Multiply: unsigned shift-add into a 2*WIDTH accumulator.
  - Divide: unsigned restoring; quotient and remainder are WIDTH each.
  - Iteration counter: clog2(WIDTH)+1 bits.
- FIX: one cycle.
  - Signed multiply: product negated if operand signs differ.
  - Signed divide: quotient negated if signs differ; remainder takes the dividend's sign.
  - Write HI/LO at FIX exit (mul: HI=product[2W-1:W], LO=product[W-1:0]; div: LO=quotient, HI=remainder). Then go to DONE.
- DONE: done_o=1 for exactly this cycle; new hi_o/lo_o visible the same cycle. Then IDLE, or CALC if a new op is accepted in this cycle.
- Latency: done_o high in the cycle after edge T+WIDTH+1. busy_o high for WIDTH+1 cycles.
- Divide by zero (b=0, DIV or DIVU): LO=all ones, HI=a_i as captured (original signed value, no sign fix). Normal latency.
- Signed overflow (MIN / -1): LO=MIN, HI=0, produced by the standard path with no special case.
- flush_i=1 in CALC or FIX: return to IDLE next edge; HI/LO unchanged; no done_o. flush_i outside CALC/FIX has no effect.
- Simultaneous flush_i and start_i in CALC/FIX: flush wins; start is dropped.
- hi_o/lo_o change only on MTHI/MTLO, FIX exit, or reset.

Optional Feature:
- Macro: MULDIV_DIVIDER_EN.
- Defined: DIV/DIVU behave as described above.
- Undefined: no divider logic is built. DIV/DIVU are accepted, enter DONE at the next edge (done_o pulses the cycle after T), busy_o stays 0, and HI/LO are unchanged. Multiply behaviour and latency are identical in both builds.

Test Plan:
- WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done_o high in the cycle after edge T+33; HI=0xFFFFFFFE, LO=0x00000001; busy_o high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0x80000000×0x80000000 -> HI=0x40000000, LO=0.
- DIV a=-7 b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7 b=0 -> LO=0xFFFFFFFF, HI=7. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x1234, then MULT 3×4, flush_i at CALC cycle 10 -> no done_o, HI=0x1234, busy_o=0 next cycle. Second start_i during CALC is ignored: only one done_o is produced.
- Back-to-back: start_i MULTU in the DONE cycle of a prior op -> accepted with no idle bubble, correct result. rst_n low mid-CALC -> hi/lo=0, busy_o=0 immediately, no done_o.
- Build without MULDIV_DIVIDER_EN: DIV 9/3 -> done_o the cycle after T, HI/LO unchanged, busy_o never asserted.
